// File: rtl/prbs_burst_arbiter.sv
// prbs_burst_arbiter
// Round-robin arbiter that shares one 4-bit PRBS source between two requesters.
// The winner's seed is loaded into a 4-bit LFSR (next = {l[2:0], l[3]^l[2]}).
// The burst is then streamed over valid/ready, tagged with the owner's ID.
// Every output is taken directly from a register.
module prbs_burst_arbiter #(
   parameter int LEN_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   input  logic [3:0]       i_req0_seed,
   input  logic [LEN_W-1:0] i_req0_len,
   input  logic             i_req1_valid,
   input  logic [3:0]       i_req1_seed,
   input  logic [LEN_W-1:0] i_req1_len,
   output logic             o_req0_ack,
   output logic             o_req1_ack,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [3:0]       o_out_data,
   output logic             o_out_id,
   output logic             o_out_last,
   output logic             o_done,
   output logic             o_seed_fixed,
   output logic             o_busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // One step of the period-15 PRBS generator.
   function automatic logic [3:0] lfsr_next(input logic [3:0] l);
      return {l[2:0], l[3] ^ l[2]};
   endfunction

   state_t           r_state, w_state;
   logic             r_rr, w_rr;
   logic [3:0]       r_lfsr, w_lfsr;
   logic [LEN_W-1:0] r_cnt, w_cnt;
   logic             r_ack0, w_ack0;
   logic             r_ack1, w_ack1;
   logic             r_valid, w_valid;
   logic             r_last, w_last;
   logic             r_id, w_id;
   logic             r_done, w_done;
   logic             r_seed_fixed, w_seed_fixed;
   logic             r_busy, w_busy;

   // A requester whose ack is on the wire this cycle may still hold valid;
   // masking it prevents a zero-length request from being accepted twice.
   logic             w_cand0, w_cand1, w_pick1;
   logic [3:0]       w_sel_seed;
   logic [LEN_W-1:0] w_sel_len;

   assign w_cand0    = i_req0_valid & ~r_ack0;
   assign w_cand1    = i_req1_valid & ~r_ack1;
   assign w_pick1    = w_cand1 & (~w_cand0 | r_rr);
   assign w_sel_seed = w_pick1 ? i_req1_seed : i_req0_seed;
   assign w_sel_len  = w_pick1 ? i_req1_len  : i_req0_len;

   // Next-state and next-output logic for the IDLE/RUN scheduler.
   always_comb begin
      w_state      = r_state;
      w_rr         = r_rr;
      w_lfsr       = r_lfsr;
      w_cnt        = r_cnt;
      w_ack0       = 1'b0;
      w_ack1       = 1'b0;
      w_valid      = r_valid;
      w_last       = r_last;
      w_id         = r_id;
      w_done       = 1'b0;
      w_seed_fixed = 1'b0;
      w_busy       = r_busy;
      case (r_state)
         ST_IDLE: begin
            if (w_cand0 || w_cand1) begin
               w_ack0       = ~w_pick1;
               w_ack1       = w_pick1;
               w_id         = w_pick1;
               w_rr         = ~w_pick1;
               w_seed_fixed = (w_sel_seed == 4'b0000);
               w_lfsr       = (w_sel_seed == 4'b0000) ? 4'b0001 : w_sel_seed;
               if (w_sel_len == {LEN_W{1'b0}}) begin
                  w_done = 1'b1;
               end else begin
                  w_state = ST_RUN;
                  w_cnt   = w_sel_len - LEN_W'(1);
                  w_valid = 1'b1;
                  w_last  = (w_sel_len == LEN_W'(1));
                  w_busy  = 1'b1;
               end
            end else begin
               w_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (r_valid && i_out_ready) begin
               w_lfsr = lfsr_next(r_lfsr);
               if (r_last) begin
                  w_state = ST_IDLE;
                  w_valid = 1'b0;
                  w_last  = 1'b0;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
               end else begin
                  w_cnt  = r_cnt - LEN_W'(1);
                  w_last = (r_cnt == LEN_W'(1));
               end
            end else begin
               w_state = ST_RUN;
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_busy  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_rr         <= 1'b0;
         r_lfsr       <= 4'b0000;
         r_cnt        <= {LEN_W{1'b0}};
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_id         <= 1'b0;
         r_done       <= 1'b0;
         r_seed_fixed <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_rr         <= w_rr;
         r_lfsr       <= w_lfsr;
         r_cnt        <= w_cnt;
         r_ack0       <= w_ack0;
         r_ack1       <= w_ack1;
         r_valid      <= w_valid;
         r_last       <= w_last;
         r_id         <= w_id;
         r_done       <= w_done;
         r_seed_fixed <= w_seed_fixed;
         r_busy       <= w_busy;
      end
   end

   assign o_req0_ack   = r_ack0;
   assign o_req1_ack   = r_ack1;
   assign o_out_valid  = r_valid;
   assign o_out_data   = r_lfsr;
   assign o_out_id     = r_id;
   assign o_out_last   = r_last;
   assign o_done       = r_done;
   assign o_seed_fixed = r_seed_fixed;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_prbs_burst_arbiter.sv
// Directed testbench for prbs_burst_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_prbs_burst_arbiter;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic [3:0]       req0_seed, req1_seed;
   logic [LEN_W-1:0] req0_len, req1_len;
   logic             req0_ack, req1_ack;
   logic             out_valid, out_ready, out_id, out_last;
   logic [3:0]       out_data;
   logic             done, seed_fixed, busy;

   int total = 0;
   int bad   = 0;

   // Burst capture buffers filled by collect().
   logic [3:0] cap_data[$];
   logic       cap_id[$];
   logic       cap_last[$];
   int         cap_wait;
   bit         cap_to;
   logic       cap_ack0, cap_ack1, cap_sf;

   // 100 MHz clock.
   always #5 clk = ~clk;

   prbs_burst_arbiter #(.LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(req0_valid), .i_req0_seed(req0_seed), .i_req0_len(req0_len),
      .i_req1_valid(req1_valid), .i_req1_seed(req1_seed), .i_req1_len(req1_len),
      .o_req0_ack(req0_ack), .o_req1_ack(req1_ack),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_data(out_data), .o_out_id(out_id), .o_out_last(out_last),
      .o_done(done), .o_seed_fixed(seed_fixed), .o_busy(busy)
   );

   // Reference PRBS step.
   function automatic logic [3:0] model_next(input logic [3:0] l);
      return {l[2:0], l[3] ^ l[2]};
   endfunction

   // Holds reset for two edges, then releases it.
   task automatic do_reset;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Records one burst with out_ready high; bounded by a cycle budget.
   task automatic collect(input bit auto_drop);
      int  guard;
      bit  fin;
      cap_data.delete(); cap_id.delete(); cap_last.delete();
      cap_wait = 0; cap_to = 1'b0; fin = 1'b0; guard = 0;
      cap_ack0 = 1'b0; cap_ack1 = 1'b0; cap_sf = 1'b0;
      out_ready = 1'b1;
      while (!fin) begin
         @(negedge clk);
         guard++;
         if (guard > 300) begin
            cap_to = 1'b1;
            fin = 1'b1;
         end else begin
            if (out_valid) begin
               if (cap_data.size() == 0) begin
                  cap_ack0 = req0_ack; cap_ack1 = req1_ack; cap_sf = seed_fixed;
               end
               cap_data.push_back(out_data);
               cap_id.push_back(out_id);
               cap_last.push_back(out_last);
               if (out_last) fin = 1'b1;
            end else if (cap_data.size() == 0) begin
               cap_wait++;
            end
            if (auto_drop && req0_ack) req0_valid = 1'b0;
            if (auto_drop && req1_ack) req1_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; out_ready = 1'b0;
      req0_valid = 1'b1; req0_seed = 4'h3; req0_len = 8'd2;
      req1_valid = 1'b1; req1_seed = 4'h5; req1_len = 8'd2;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({req0_ack, req1_ack, out_valid, out_last, done, seed_fixed, busy} !== 7'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 0000000",
                         {req0_ack, req1_ack, out_valid, out_last, done, seed_fixed, busy});
      end
      total++;
      if ({out_data, out_id} !== 5'b0) begin
         bad++; $display("FAIL reset_data_id: got %b want 00000", {out_data, out_id});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({req0_ack, req1_ack, out_valid, busy} !== 4'b0) begin
         bad++; $display("FAIL reset_idle: got %b want 0000", {req0_ack, req1_ack, out_valid, busy});
      end
   endtask

   task automatic test_single;
      logic [3:0] exp_d [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};
      do_reset();
      req0_seed = 4'b1000; req0_len = 8'd5; req0_valid = 1'b1;
      collect(1'b1);
      total++;
      if (cap_to !== 1'b0 || cap_data.size() != 5) begin
         bad++; $display("FAIL single_count: got %0d words (timeout=%0b) want 5", cap_data.size(), cap_to);
      end else begin
         for (int k = 0; k < 5; k++) begin
            total++;
            if (cap_data[k] !== exp_d[k] || cap_id[k] !== 1'b0 || cap_last[k] !== (k == 4)) begin
               bad++; $display("FAIL single_word%0d: got data=%b id=%b last=%b want data=%b id=0 last=%0b",
                               k, cap_data[k], cap_id[k], cap_last[k], exp_d[k], (k == 4));
            end
         end
      end
      total++;
      if (cap_ack0 !== 1'b1 || cap_ack1 !== 1'b0 || cap_wait != 0) begin
         bad++; $display("FAIL single_ack: got ack0=%b ack1=%b wait=%0d want 1 0 0", cap_ack0, cap_ack1, cap_wait);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL single_done: got done=%b valid=%b busy=%b want 1 0 0", done, out_valid, busy);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++; $display("FAIL single_done_pulse: got %b want 0", done);
      end
   endtask

   task automatic test_simultaneous;
      do_reset();
      req0_seed = 4'b0001; req0_len = 8'd2; req0_valid = 1'b1;
      req1_seed = 4'b1111; req1_len = 8'd2; req1_valid = 1'b1;
      collect(1'b1);
      total++;
      if (cap_data.size() != 2 || cap_data[0] !== 4'b0001 || cap_data[1] !== 4'b0010 ||
          cap_id[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
         bad++; $display("FAIL simul_first: got n=%0d d0=%b d1=%b id=%b want n=2 0001 0010 id=0",
                         cap_data.size(), cap_data[0], cap_data[1], cap_id[0]);
      end
      collect(1'b1);
      total++;
      if (cap_data.size() != 2 || cap_data[0] !== 4'b1111 || cap_data[1] !== 4'b1110 ||
          cap_id[0] !== 1'b1 || cap_id[1] !== 1'b1 || cap_ack1 !== 1'b1) begin
         bad++; $display("FAIL simul_second: got n=%0d d0=%b d1=%b id=%b ack1=%b want n=2 1111 1110 id=1 ack1=1",
                         cap_data.size(), cap_data[0], cap_data[1], cap_id[0], cap_ack1);
      end
      total++;
      if (cap_wait != 1) begin
         bad++; $display("FAIL simul_gap: got %0d idle cycles want 1", cap_wait);
      end
      @(negedge clk);
   endtask

   task automatic test_fairness;
      logic ids [6];
      do_reset();
      req0_seed = 4'b0011; req0_len = 8'd1; req0_valid = 1'b1;
      req1_seed = 4'b0110; req1_len = 8'd1; req1_valid = 1'b1;
      for (int b = 0; b < 6; b++) begin
         collect(1'b0);
         ids[b] = (cap_data.size() > 0) ? cap_id[0] : 1'bx;
         total++;
         if (cap_data.size() != 1 || cap_data[0] !== (b[0] ? 4'b0110 : 4'b0011)) begin
            bad++; $display("FAIL fair_data%0d: got n=%0d d=%b want n=1 d=%b",
                            b, cap_data.size(), cap_data[0], (b[0] ? 4'b0110 : 4'b0011));
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int b = 0; b < 6; b++) begin
         total++;
         if (ids[b] !== b[0]) begin
            bad++; $display("FAIL fair_grant%0d: got id=%b want %b", b, ids[b], b[0]);
         end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [3:0] exp_d [5] = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      logic       rdy   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      req0_seed = 4'b1000; req0_len = 8'd3; req0_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) req0_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || out_data !== exp_d[c] || out_last !== (c == 4) || out_id !== 1'b0) begin
            bad++; $display("FAIL bp_cycle%0d: got valid=%b data=%b last=%b id=%b want 1 %b %0b 0",
                            c, out_valid, out_data, out_last, out_id, exp_d[c], (c == 4));
         end
         out_ready = rdy[c];
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_done: got done=%b valid=%b want 1 0", done, out_valid);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_seed_zero;
      do_reset();
      req1_seed = 4'b0000; req1_len = 8'd2; req1_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (req1_ack !== 1'b1 || seed_fixed !== 1'b1 || out_data !== 4'b0001 || out_id !== 1'b1 || out_valid !== 1'b1) begin
         bad++; $display("FAIL seed0_first: got ack1=%b fixed=%b data=%b id=%b valid=%b want 1 1 0001 1 1",
                         req1_ack, seed_fixed, out_data, out_id, out_valid);
      end
      req1_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_data !== 4'b0010 || out_last !== 1'b1 || seed_fixed !== 1'b0 || req1_ack !== 1'b0) begin
         bad++; $display("FAIL seed0_second: got data=%b last=%b fixed=%b ack1=%b want 0010 1 0 0",
                         out_data, out_last, seed_fixed, req1_ack);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL seed0_done: got %b want 1", done);
      end
   endtask

   task automatic test_len_zero;
      do_reset();
      req0_seed = 4'b0101; req0_len = 8'd0; req0_valid = 1'b1;
      @(negedge clk);
      total++;
      if (req0_ack !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL len0_pulse: got ack0=%b done=%b valid=%b busy=%b want 1 1 0 0",
                         req0_ack, done, out_valid, busy);
      end
      @(negedge clk);
      total++;
      if (req0_ack !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL len0_single: got ack0=%b done=%b valid=%b want 0 0 0", req0_ack, done, out_valid);
      end
      req0_seed = 4'b0011; req0_len = 8'd1;
      req1_seed = 4'b0110; req1_len = 8'd1; req1_valid = 1'b1;
      collect(1'b1);
      total++;
      if (cap_data.size() != 1 || cap_id[0] !== 1'b1 || cap_data[0] !== 4'b0110) begin
         bad++; $display("FAIL len0_rr: got n=%0d id=%b data=%b want n=1 id=1 data=0110",
                         cap_data.size(), cap_id[0], cap_data[0]);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_len17;
      logic [3:0] m;
      do_reset();
      req0_seed = 4'b1000; req0_len = 8'd17; req0_valid = 1'b1;
      collect(1'b1);
      total++;
      if (cap_to !== 1'b0 || cap_data.size() != 17) begin
         bad++; $display("FAIL len17_count: got %0d words (timeout=%0b) want 17", cap_data.size(), cap_to);
      end else begin
         m = 4'b1000;
         for (int k = 0; k < 17; k++) begin
            total++;
            if (cap_data[k] !== m || cap_last[k] !== (k == 16)) begin
               bad++; $display("FAIL len17_word%0d: got data=%b last=%b want %b %0b",
                               k, cap_data[k], cap_last[k], m, (k == 16));
            end
            m = model_next(m);
         end
         total++;
         if (cap_data[15] !== 4'b1000 || cap_data[16] !== 4'b0001) begin
            bad++; $display("FAIL len17_wrap: got w16=%b w17=%b want 1000 0001", cap_data[15], cap_data[16]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      do_reset();
      req0_seed = 4'b1000; req0_len = 8'd10; req0_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 0) req0_valid = 1'b0;
      end
      total++;
      if (out_data !== 4'b0010 || out_valid !== 1'b1) begin
         bad++; $display("FAIL rstmid_pre: got data=%b valid=%b want 0010 1", out_data, out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0 || out_data !== 4'b0000) begin
         bad++; $display("FAIL rstmid_abort: got valid=%b busy=%b done=%b last=%b data=%b want 0 0 0 0 0000",
                         out_valid, busy, done, out_last, out_data);
      end
      rst = 1'b0;
      req0_seed = 4'b0001; req0_len = 8'd2; req0_valid = 1'b1;
      req1_seed = 4'b1111; req1_len = 8'd2; req1_valid = 1'b1;
      collect(1'b1);
      total++;
      if (cap_data.size() != 2 || cap_id[0] !== 1'b0 || cap_data[0] !== 4'b0001) begin
         bad++; $display("FAIL rstmid_rr: got n=%0d id=%b data=%b want n=2 id=0 data=0001",
                         cap_data.size(), cap_id[0], cap_data[0]);
      end
      collect(1'b1);
      total++;
      if (cap_data.size() != 2 || cap_id[0] !== 1'b1) begin
         bad++; $display("FAIL rstmid_second: got n=%0d id=%b want n=2 id=1", cap_data.size(), cap_id[0]);
      end
      @(negedge clk);
   endtask

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   // Test sequence.
   initial begin
      rst = 1'b1; out_ready = 1'b0;
      req0_valid = 1'b0; req0_seed = 4'h0; req0_len = '0;
      req1_valid = 1'b0; req1_seed = 4'h0; req1_len = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_seed_zero();
      test_len_zero();
      test_len17();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs_burst_arbiter.md
# prbs_burst_arbiter

Round-robin scheduler that shares one 4-bit PRBS source between two requesters. Each requester submits a seed and a burst length. The block grants one requester at a time, loads its seed into an internal 4-bit LFSR (next = {l[2:0], l[3]^l[2]}, period 15, matching the team's PRBS generator), and streams the burst words out over a valid/ready interface tagged with the owner's ID. It sits between the PRBS generator logic and the test-pattern consumers.

## Interface
- LEN_W, 8, width of burst-length fields and internal beat counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  burst request, held until matching ack
- req0_seed / req1_seed  in  4  LFSR seed for that burst
- req0_len / req1_len  in  LEN_W  number of words in the burst
- req0_ack / req1_ack  out  1  one-cycle pulse: request accepted
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the word
- out_data  out  4  current PRBS word
- out_id  out  1  owner of the current burst
- out_last  out  1  final word of the burst
- done  out  1  one-cycle pulse: burst finished
- seed_fixed  out  1  one-cycle pulse with ack: a zero seed was replaced
- busy  out  1  state is RUN

## Operation
- Two states: IDLE, RUN. All outputs are registered.
- Reset values: state IDLE, rr=0, all acks/done/seed_fixed/out_valid/out_last/busy = 0, out_data=0, out_id=0, counter=0.
- Request selection in IDLE:
  - Candidates are the reqN_valid bits. If both are valid, rr decides: rr=0 picks req0, rr=1 picks req1.
  - On the accepting edge: ack of the winner is 1 next cycle, out_id=winner, rr=~winner, and the LFSR is loaded.
  - LFSR load value is the seed, or 4'b0001 if the seed is 0. A zero seed also pulses seed_fixed alongside the ack.
- Zero length: if len==0, state stays IDLE. ack and done pulse together in the next cycle and no words are emitted. rr still toggles.
- Nonzero length: state goes to RUN. The counter is loaded with len-1, out_valid=1, out_last=(len==1), busy=1.
- RUN:
  - out_data = LFSR value.
  - On each out_valid&&out_ready edge: LFSR advances, counter decrements, and out_last=(counter==1).
  - On the handshake edge where out_last=1: state goes to IDLE, out_valid=0, out_last=0, busy=0, and done=1 for one cycle.
- No handshake: out_valid, out_data, out_id and out_last hold steady while out_ready=0.
- Requests arriving in RUN are not sampled. The requester keeps valid high until acked.
- The non-granted requester is not starved: after any grant, the other requester has priority.
- Lengths up to 2^LEN_W-1 are supported. Words wrap with period 15, so word k equals word k+15.
- Reset mid-burst: the next edge with rst=1 aborts the burst. All outputs return to reset values, no done pulse is issued, and rr=0.

## Timing
- Request accept latency: valid sampled at edge e, so ack, out_valid and the first word appear in cycle e+1.
- Requester protocol: must drop valid (or present a new request) by edge e+2. The block ignores valid during RUN, so holding it one extra cycle is harmless.
- Throughput: one word per cycle while out_ready=1. A burst of L words with out_ready tied high occupies L cycles of out_valid.
- Gap between bursts: done coincides with the first IDLE cycle. A new request sampled at the end of that cycle produces its first word on the following cycle, so there is exactly one idle cycle between bursts.
- ack and done are single-cycle pulses and are never asserted during reset.

## Test plan
- Single burst: req0 seed=4'b1000, len=5, out_ready=1. Required: ack0 pulse, then words 1000, 0001, 0010, 0100, 1001 with out_id=0, out_last on the 5th word, done in the next cycle.
- Simultaneous requests after reset: req0 (seed 1, len 2) and req1 (seed 4'b1111, len 2) both valid. Required: req0 served first (0001, 0010), then req1 (1111, 1110, out_id=1).
- Round-robin fairness: both requests held continuously for 6 bursts. Required: grants alternate 0, 1, 0, 1, ... with no back-to-back repeat.
- Backpressure: len=3, out_ready toggling 1, 0, 0, 1, 1. Required: out_data holds during stalls, the sequence is unchanged, and the last word is accepted on the 5th cycle.
- Edge cases:
  - seed=0 with len=2 yields seed_fixed=1 and words 0001, 0010.
  - len=0 yields ack and done in the same cycle with no out_valid.
  - len=17 from seed 1000 yields word 16 = 1000 and word 17 = 0001 (period-15 wrap).
- Reset mid-burst: assert rst on the 3rd word of a len=10 burst. Required: next cycle has out_valid=0, busy=0, no done, rr=0. A subsequent dual request serves req0 first.
